// File: rtl/data_mem_arbiter_if.sv
// Request/response and memory-pin bundle between two requesters, the arbiter and data_mem.
// Handshake: a request transfers on a cycle where reqN_valid && reqN_ready; the requester
//   holds valid and its fields stable until then, and dropping valid earlier cancels it.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_address, mem_write_data, mem_write_enable,
    input  mem_read_data
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_address, mem_write_data, mem_write_enable,
    output mem_read_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer driving the single-port 64x8 data_mem (IDLE -> ISSUE -> CAPTURE).
// Define DATA_MEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module data_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  data_mem_arbiter_if.slave  bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              is_read_q, is_read_d;
  logic              port_q, port_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
`ifdef DATA_MEM_ARB_RR_EN
  logic              last_grant_q, last_grant_d;
`endif

  logic pick1;
  logic ready0;
  logic ready1;

  always_comb begin
`ifdef DATA_MEM_ARB_RR_EN
    // On a tie, the port that was not granted last wins.
    pick1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
`else
    pick1 = bus.req1_valid & ~bus.req0_valid;
`endif
    ready0 = (state_q == IDLE) & bus.req0_valid & ~pick1;
    ready1 = (state_q == IDLE) & pick1;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_we_d  = mem_we_q;
    is_read_d = is_read_q;
    port_d    = port_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (ready0 | ready1) begin
          state_d   = ISSUE;
          addr_d    = pick1 ? bus.req1_addr  : bus.req0_addr;
          wdata_d   = pick1 ? bus.req1_wdata : bus.req0_wdata;
          mem_we_d  = pick1 ? bus.req1_we    : bus.req0_we;
          is_read_d = pick1 ? ~bus.req1_we   : ~bus.req0_we;
          port_d    = pick1;
`ifdef DATA_MEM_ARB_RR_EN
          last_grant_d = pick1;
`endif
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        state_d  = is_read_q ? CAPTURE : IDLE;
      end
      CAPTURE: begin
        // Address is still held, so data_mem's registered output now reflects this line.
        state_d = IDLE;
        if (port_q) begin
          rdata1_d  = bus.mem_read_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = bus.mem_read_data;
          rvalid0_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_we_q  <= 1'b0;
      is_read_q <= 1'b0;
      port_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef DATA_MEM_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_we_q  <= mem_we_d;
      is_read_q <= is_read_d;
      port_q    <= port_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifdef DATA_MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.req0_ready       = ready0;
  assign bus.req1_ready       = ready1;
  assign bus.req0_rvalid      = rvalid0_q;
  assign bus.req1_rvalid      = rvalid1_q;
  assign bus.req0_rdata       = rdata0_q;
  assign bus.req1_rdata       = rdata1_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.mem_write_enable = mem_we_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus two random requesters, checked by a
// per-cycle reference model of grants, memory pins and read responses.
module tb_data_mem_arbiter;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;
  localparam int W      = 25;  // {due_cycle[15:0], port, data[7:0]}

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] init_val [64];
  logic [7:0] mem      [64];
  bit         init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
    end else begin
      if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;
      bus.mem_read_data <= mem[bus.mem_address];
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: event did not occur as expected (cycle %0d)", name, cyc);
  endtask

  // Reference model: a shadow copy of memory updated in accept order, a busy-until
  // cycle, the last granted port and the request now on the memory pins.
  logic [7:0] shadow [64];
  int         next_free = 0;
  int         issue_cyc = -10;
  bit         lg = 1'b1;
  logic       issue_we = 1'b0;
  logic [5:0] issue_addr = '0;
  logic [7:0] issue_wdata = '0;
  logic [7:0] pend_old = '0;
  logic [7:0] rdm0 = '0;
  logic [7:0] rdm1 = '0;
  bit         acc0, acc1;
  int         acc_cyc0 = 0;

  always @(negedge clk) begin
    bit e0, e1, p, we;
    logic [5:0] a;
    logic [7:0] d;
    logic [W-1:0] e;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!init_done) for (int i = 0; i < 64; i++) shadow[i] = init_val[i];
    if (!reset_n) begin
      chk("reset_ctrl", 32'({bus.req0_ready, bus.req1_ready, bus.req0_rvalid,
                             bus.req1_rvalid, bus.mem_write_enable}), 32'd0);
      chk("reset_data", 32'({bus.req0_rdata, bus.req1_rdata, bus.mem_address}), 32'd0);
      chk("reset_wdata", 32'(bus.mem_write_data), 32'd0);
      // A write caught in its memory cycle never lands.
      if (issue_we && cyc == issue_cyc) shadow[issue_addr] = pend_old;
      exp_q.delete();
      next_free = cyc + 1;
      issue_cyc = -10;
      lg = 1'b1;
      issue_we = 1'b0;
      issue_addr = '0;
      issue_wdata = '0;
      rdm0 = '0;
      rdm1 = '0;
    end else begin
      chk("mem_write_enable", 32'(bus.mem_write_enable), 32'((cyc == issue_cyc) && issue_we));
      chk("mem_address", 32'(bus.mem_address), 32'(issue_addr));
      chk("mem_write_data", 32'(bus.mem_write_data), 32'(issue_wdata));

      if (bus.req0_rvalid || bus.req1_rvalid) begin
        if (exp_q.size() == 0) begin
          fail_now("rvalid_unexpected");
        end else begin
          e = exp_q.pop_front();
          chk("rvalid_port", 32'({bus.req1_rvalid, bus.req0_rvalid}), e[8] ? 32'd2 : 32'd1);
          chk("rvalid_latency", 32'(cyc[15:0]), 32'(e[24:9]));
          if (e[8]) rdm1 = e[7:0];
          else      rdm0 = e[7:0];
        end
      end else if (exp_q.size() != 0 && exp_q[0][24:9] == cyc[15:0]) begin
        fail_now("rvalid_missing");
        void'(exp_q.pop_front());
      end
      chk("req0_rdata", 32'(bus.req0_rdata), 32'(rdm0));
      chk("req1_rdata", 32'(bus.req1_rdata), 32'(rdm1));

      e0 = 1'b0;
      e1 = 1'b0;
      if (cyc >= next_free) begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef DATA_MEM_ARB_RR_EN
          if (lg) e0 = 1'b1;
          else    e1 = 1'b1;
`else
          e0 = 1'b1;
`endif
        end else begin
          e0 = bus.req0_valid;
          e1 = bus.req1_valid;
        end
      end
      chk("req0_ready", 32'(bus.req0_ready), 32'(e0));
      chk("req1_ready", 32'(bus.req1_ready), 32'(e1));
      acc0 = bus.req0_valid & bus.req0_ready;
      acc1 = bus.req1_valid & bus.req1_ready;

      if (e0 || e1) begin
        p  = e1;
        we = p ? bus.req1_we    : bus.req0_we;
        a  = p ? bus.req1_addr  : bus.req0_addr;
        d  = p ? bus.req1_wdata : bus.req0_wdata;
        lg = p;
        issue_cyc   = cyc + 1;
        issue_we    = we;
        issue_addr  = a;
        issue_wdata = d;
        next_free   = cyc + (we ? 2 : 3);
        if (e0) acc_cyc0 = cyc;
        if (we) begin
          pend_old  = shadow[a];
          shadow[a] = d;
        end else begin
          exp_q.push_back({16'(cyc + 3), p, shadow[a]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input bit v, input bit we, input logic [5:0] a,
                       input logic [7:0] d);
    if (p) begin
      bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
    end else begin
      bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
    end
  endtask

  task automatic req(input bit p, input bit we, input logic [5:0] a, input logic [7:0] d);
    bit done = 1'b0;
    drive(p, 1'b1, we, a, d);
    for (int k = 0; k < 200 && !done; k++) begin
      step();
      if (p ? acc1 : acc0) done = 1'b1;
    end
    if (!done) fail_now(p ? "req1_accept_timeout" : "req0_accept_timeout");
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_port(input bit p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) step();
      req(p, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 8'($urandom));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seq[$];
    int first_acc;
    for (int i = 0; i < 64; i++) init_val[i] = 8'($urandom);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    init_done = 1'b1;
    chk("dbg_state_reset", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Both ports valid continuously: reads of 0x01 and 0x02.
    drive(1'b0, 1'b1, 1'b0, 6'h01, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 6'h02, 8'h00);
    for (int k = 0; k < 40 && seq.size() < 4; k++) begin
      step();
      if (acc0) seq.push_back(0);
      if (acc1) seq.push_back(1);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("grant_count", 32'(seq.size()), 32'd4);
    for (int i = 0; i < seq.size(); i++) begin
`ifdef DATA_MEM_ARB_RR_EN
      chk("grant_seq", 32'(seq[i]), 32'(i % 2));
`else
      chk("grant_seq", 32'(seq[i]), 32'd0);
`endif
    end
    repeat (4) step();

    // Single write, then read-back on the other port.
    req(1'b0, 1'b1, 6'h05, 8'hA5);
    repeat (3) step();
    req(1'b1, 1'b0, 6'h05, 8'h00);
    repeat (4) step();
    chk("readback_rdata1", 32'(bus.req1_rdata), 32'hA5);

    // Back-to-back write then read of the same line.
    req(1'b0, 1'b1, 6'h3F, 8'h11);
    first_acc = acc_cyc0;
    req(1'b0, 1'b0, 6'h3F, 8'h00);
    chk("b2b_accept_gap", 32'(acc_cyc0 - first_acc), 32'd2);
    repeat (4) step();
    chk("b2b_rdata0", 32'(bus.req0_rdata), 32'h11);

    // Reset while a write sits in its memory cycle.
    req(1'b0, 1'b1, 6'h10, 8'h3C);
    repeat (2) step();
    req(1'b0, 1'b1, 6'h10, 8'hFF);
    #1 reset_n = 1'b0;
    #1 chk("reset_drops_we", 32'(bus.mem_write_enable), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    req(1'b0, 1'b0, 6'h10, 8'h00);
    repeat (4) step();
    chk("reset_keeps_old", 32'(bus.req0_rdata), 32'h3C);

    // Port 1 raises and drops a write while the arbiter is busy.
    req(1'b0, 1'b0, 6'h20, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 6'h21, 8'h77);
    repeat (2) step();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (5) step();
    chk("cancel_no_write", 32'(mem[6'h21]), 32'(init_val[6'h21]));

    // Random traffic from both requesters.
    fork
      rand_port(1'b0, 30);
      rand_port(1'b1, 30);
    join
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the 64 x 8 single-port synchronous data memory (`data_mem`). It accepts read/write requests from two masters (port 0: CPU load/store unit, port 1: memory loader/debug port) over a valid/ready handshake. It serialises the requests onto the memory's `data_address`/`write_data`/`write_enable` pins and returns read data with a one-cycle `rvalid` pulse. It sits between the core datapath and `data_mem`, and is the only driver of the memory pins.

## Interface
Parameters:
- `ADDR_W`, 6: memory address width (64 lines).
- `DATA_W`, 8: data width.

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request pending on port i.
- `req0_we`, `req1_we`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  ADDR_W  request address.
- `req0_wdata`, `req1_wdata`  in  DATA_W  write data.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (valid & ready).
- `req0_rvalid`, `req1_rvalid`  out  1  one-cycle pulse: read data valid.
- `req0_rdata`, `req1_rdata`  out  DATA_W  read data, held until that port's next read completes.
- `mem_address`  out  ADDR_W  to `data_mem.data_address`.
- `mem_write_data`  out  DATA_W  to `data_mem.write_data`.
- `mem_write_enable`  out  1  to `data_mem.write_enable`.
- `mem_read_data`  in  DATA_W  from `data_mem.read_data` (registered, 1-cycle latency).

## Operation
- FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: winner chosen combinationally among valid ports; `reqN_ready` = 1 for the winner only. On the accept edge, the request's addr, wdata, we and port id are registered onto the mem pins/state. Next state ISSUE. No valid request: stay in IDLE.
  - ISSUE: the mem pins carry the request, with `mem_write_enable` = we. The memory performs the op at the end of this cycle. Next state: IDLE if write, CAPTURE if read.
  - CAPTURE: `mem_write_enable` = 0 and `mem_address` held, so the memory re-reads the same line. At the end of the cycle `mem_read_data` is registered into the owning port's `rdata` and that port's `rvalid` is set. Next state IDLE.
- `rvalid` is high for exactly one cycle, the cycle after CAPTURE.
- `mem_write_enable` is 1 only in ISSUE for a write.
- `mem_address` and `mem_write_data` hold their last value outside ISSUE.
- `ready` is asserted only in IDLE. A requester holds valid and its fields until ready. Dropping valid before ready cancels the request with no side effect.
- Arbitration: see Configuration. `last_grant` updates on each accept.
- Reset (async, any state): FSM goes to IDLE; all outputs go to 0, including `rdata`, `mem_address`, `mem_write_data` and `mem_write_enable`. `last_grant` = 1, so port 0 wins the first tie. An in-flight op is dropped: no `rvalid`, and a write in ISSUE is suppressed by the async clear of `mem_write_enable`.

## Timing
- Read: accept at edge E, ISSUE in cycle E+1, CAPTURE in E+2, `rvalid` in E+3. Read latency is 3 cycles from accept to `rvalid`.
- Write: accept at E, memory written at the end of E+1, IDLE in E+2. Throughput is 1 write per 2 cycles.
- A new request can be accepted in the same cycle that `rvalid` pulses, giving a throughput of 1 read per 3 cycles.
- Back-to-back same-address write then read returns the new data, because the write completes before the read's ISSUE.
- No combinational path from `mem_read_data` to any output.

## Configuration
- `DATA_MEM_ARB_RR_EN`
  - Defined: round-robin. When both ports are valid in IDLE, the port not equal to `last_grant` wins. A single valid port always wins.
  - Undefined: fixed priority, port 0 always wins. `last_grant` is not implemented. Port 1 can starve under continuous port-0 traffic.

## Test plan
- Reset then single write: port 0 writes addr 0x05 = 0xA5 → `req0_ready` high 1 cycle. Next cycle: `mem_write_enable` = 1, `mem_address` = 0x05, `mem_write_data` = 0xA5. IDLE two cycles after accept.
- Read-back: port 1 reads 0x05 after the above → `req1_rvalid` pulses exactly 3 cycles after accept with `req1_rdata` = 0xA5. `req0_rvalid` stays 0.
- Simultaneous requests: both ports valid continuously, with 0 reading 0x01 and 1 reading 0x02. With `DATA_MEM_ARB_RR_EN`, grants alternate 0,1,0,1. Without it, port 0 is granted every time and port 1 never.
- Back-to-back: port 0 writes 0x3F = 0x11, then immediately reads 0x3F → second ready 2 cycles after the first, then `rdata` = 0x11.
- Reset mid-write: assert `reset_n` = 0 during ISSUE of a write 0x10 = 0xFF → `mem_write_enable` drops immediately and the line keeps its old value. After release, a read of 0x10 returns the old value and all outputs are 0 during reset.
- Cancelled request: port 1 raises valid while busy, then drops it before ready → no memory access and no `rvalid` for port 1.
